// File: rtl/ldpc_pkg.sv
// Shared constants and types for the LDPC prototype-matrix loader: lifting sizes,
// bank geometry, the zero-block marker and the loader FSM state encoding.
`timescale 1ns/1ps
package ldpc_pkg;

  localparam int BANK_DEPTH = 96;
  localparam int ENTRY_W    = 7;
  localparam logic [ENTRY_W-1:0] SKIP = '1;

  localparam int Z_VALUES [3] = '{27, 54, 81};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE,
    ST_ERR
  } loader_state_e;

  // Lifting size of a bank; unknown banks map to 0 so nothing is ever in range.
  function automatic int z_of(input logic [1:0] bank);
    case (bank)
      2'd0:    return Z_VALUES[0];
      2'd1:    return Z_VALUES[1];
      2'd2:    return Z_VALUES[2];
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/proto_matrix_ram.sv
// Simple dual-port storage for all prototype-matrix banks: one write port and one
// registered, read-first read port, written so synthesis maps it onto block RAM.
`timescale 1ns/1ps
module proto_matrix_ram #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 288,
  parameter int ADDRW = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [ADDRW-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [ADDRW-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset on purpose; a reset loop would stop block-RAM inference.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Non-blocking write plus registered read gives old data on a same-address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/proto_matrix_loader.sv
// Loads one prototype-matrix bank from a valid/ready entry stream and serves reads.
// Optional value range checking against the bank's Z: PROTO_LOADER_RANGE_CHECK_EN.
`timescale 1ns/1ps
module proto_matrix_loader #(
  parameter int NUM_Z      = 3,
  parameter int BANK_DEPTH = 96,
  parameter int WIDTH      = 7,
  parameter int ADDRW      = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       bank_sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic [ADDRW-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [NUM_Z-1:0] bank_valid
);

  import ldpc_pkg::*;

  localparam int TOTAL = NUM_Z * BANK_DEPTH;
  localparam int CNTW  = $clog2(BANK_DEPTH + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(BANK_DEPTH - 1);

  loader_state_e    state_q, state_d;
  logic [CNTW-1:0]  cnt_q;
  logic [1:0]       bank_q;
  logic             accept_start;
  logic             wr_en;
  logic             range_bad;
  logic             rd_en;
  logic             oob_q;
  logic [ADDRW-1:0] wr_addr;
  logic [WIDTH-1:0] ram_rd;

`ifdef PROTO_LOADER_RANGE_CHECK_EN
  assign range_bad = (in_data != '1) && (32'(in_data) >= z_of(bank_q));
`else
  assign range_bad = 1'b0;
`endif

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    in_ready     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    accept_start = 1'b0;
    wr_en        = 1'b0;
    case (state_q)
      ST_IDLE, ST_ERR: begin
        err = (state_q == ST_ERR);
        if (start) begin
          if (32'(bank_sel) < NUM_Z) begin
            accept_start = 1'b1;
            state_d      = ST_LOAD;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          if (range_bad) begin
            state_d = ST_ERR;
          end else begin
            wr_en = 1'b1;
            if (cnt_q == CNT_LAST) begin
              state_d = in_last ? ST_DONE : ST_ERR;
            end else if (in_last) begin
              state_d = ST_ERR;
            end
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bank_q     <= '0;
      bank_valid <= '0;
    end else begin
      state_q <= state_d;
      if (accept_start) begin
        bank_q               <= bank_sel;
        cnt_q                <= '0;
        bank_valid[bank_sel] <= 1'b0;
      end
      if (wr_en) begin
        cnt_q <= cnt_q + 1'b1;
      end
      // The image becomes valid together with the done pulse.
      if (state_q == ST_LOAD && state_d == ST_DONE) begin
        bank_valid[bank_q] <= 1'b1;
      end
    end
  end

  assign wr_addr = ADDRW'(32'(bank_q) * BANK_DEPTH + 32'(cnt_q));
  assign rd_en   = (32'(rd_addr) < TOTAL);

  proto_matrix_ram #(
    .WIDTH (WIDTH),
    .DEPTH (TOTAL),
    .ADDRW (ADDRW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (in_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (ram_rd)
  );

  // Out-of-range reads are flagged alongside the RAM read and replaced by the skip marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      oob_q <= 1'b0;
    end else begin
      oob_q <= !rd_en;
    end
  end

  assign rd_data = oob_q ? '1 : ram_rd;

endmodule

// File: tb/tb_proto_matrix_loader.sv
// Randomized scoreboard bench for proto_matrix_loader: a behavioural model predicts
// load outcomes and memory contents; a monitor compares done/err events and reads.
`timescale 1ns/1ps
module tb_proto_matrix_loader;

  localparam int NUM_Z      = 3;
  localparam int BANK_DEPTH = 96;
  localparam int WIDTH      = 7;
  localparam int ADDRW      = 9;
  localparam int TOTAL      = NUM_Z * BANK_DEPTH;
`ifdef PROTO_LOADER_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       bank_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic [ADDRW-1:0] rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             done;
  logic             err;
  logic [NUM_Z-1:0] bank_valid;

  always #5 clk = ~clk;

  proto_matrix_loader #(
    .NUM_Z      (NUM_Z),
    .BANK_DEPTH (BANK_DEPTH),
    .WIDTH      (WIDTH),
    .ADDRW      (ADDRW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bank_sel   (bank_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .bank_valid (bank_valid)
  );

  typedef struct {
    bit               is_done;
    logic [NUM_Z-1:0] bv;
  } ev_t;

  int               checks = 0;
  int               errors = 0;
  ev_t              ev_q [$];
  logic [WIDTH-1:0] rd_q [$];
  logic [ADDRW-1:0] rda_q [$];
  logic [WIDTH-1:0] model_mem [TOTAL];
  logic [NUM_Z-1:0] model_bv;
  bit               model_err;
  logic             rd_req;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int zval(input int bank);
    case (bank)
      0:       return 27;
      1:       return 54;
      default: return 81;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] exp_rd(input logic [ADDRW-1:0] a);
    if (int'(a) >= TOTAL) return '1;
    return model_mem[a];
  endfunction

  // Monitor: pops expected read data and done/err events whenever the DUT presents them.
  initial begin : monitor
    bit  pend;
    bit  err_prev;
    ev_t e;
    err_prev = 1'b0;
    forever begin
      @(posedge clk);
      pend = rd_req;
      @(negedge clk);
      if (pend) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected: got read response with nothing expected");
        end else begin
          check($sformatf("rd_data@%0d", rda_q.pop_front()), 32'(rd_data), 32'(rd_q.pop_front()));
        end
      end
      if (done || (err && !err_prev)) begin
        if (ev_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event: got done=%0b err=%0b with no event expected", done, err);
        end else begin
          e = ev_q.pop_front();
          check(e.is_done ? "event_is_done" : "event_is_err", 32'(done), 32'(e.is_done));
          check("event_bank_valid", 32'(bank_valid), 32'(e.bv));
          check("event_in_ready", 32'(in_ready), 32'd0);
        end
      end
      err_prev = err;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start(input int bank);
    start    = 1'b1;
    bank_sel = 2'(bank);
    if (bank < NUM_Z) begin
      model_bv[bank] = 1'b0;
      model_err      = 1'b0;
    end else if (!model_err) begin
      ev_q.push_back('{is_done: 1'b0, bv: model_bv});
      model_err = 1'b1;
    end
    tick();
    start = 1'b0;
  endtask

  task automatic do_read(input logic [ADDRW-1:0] a);
    rd_req  = 1'b1;
    rd_addr = a;
    rd_q.push_back(exp_rd(a));
    rda_q.push_back(a);
    tick();
    rd_req = 1'b0;
  endtask

  // pat 0: value i mod Z; pat 1: random in-range values with occasional skip markers.
  task automatic do_load(input int bank, input int last_beat, input int pat,
                         input int bad_beat, input logic [WIDTH-1:0] bad_val, input bit gaps,
                         input int rd_beat, input logic [ADDRW-1:0] rd_a, input int rst_beat);
    int               z;
    int               base;
    bit               stop;
    logic [WIDTH-1:0] v;
    pulse_start(bank);
    check("busy_after_start", 32'(busy), 32'(bank < NUM_Z));
    if (bank >= NUM_Z) return;
    check("err_after_start", 32'(err), 32'd0);
    z    = zval(bank);
    base = bank * BANK_DEPTH;
    stop = 1'b0;
    for (int i = 0; i < BANK_DEPTH && !stop; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
      end
      if (i == rst_beat) begin
        in_valid  = 1'b0;
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
        model_bv  = '0;
        model_err = 1'b0;
        check("busy_after_rst", 32'(busy), 32'd0);
        check("bank_valid_after_rst", 32'(bank_valid), 32'd0);
        return;
      end
      if (i == bad_beat) v = bad_val;
      else if (pat == 0) v = WIDTH'(i % z);
      else v = ($urandom_range(0, 9) == 0) ? 7'h7F : WIDTH'($urandom_range(0, z - 1));
      in_valid = 1'b1;
      in_data  = v;
      in_last  = (i == last_beat);
      if (i == rd_beat) begin
        rd_req  = 1'b1;
        rd_addr = rd_a;
        rd_q.push_back(exp_rd(rd_a));
        rda_q.push_back(rd_a);
      end
      if (RANGE_EN && v != 7'h7F && int'(v) >= z) begin
        ev_q.push_back('{is_done: 1'b0, bv: model_bv});
        model_err = 1'b1;
        stop      = 1'b1;
      end else begin
        model_mem[base + i] = v;
        if (i == BANK_DEPTH - 1 && i == last_beat) begin
          model_bv[bank] = 1'b1;
          ev_q.push_back('{is_done: 1'b1, bv: model_bv});
          stop = 1'b1;
        end else if (i == last_beat || i == BANK_DEPTH - 1) begin
          ev_q.push_back('{is_done: 1'b0, bv: model_bv});
          model_err = 1'b1;
          stop      = 1'b1;
        end
      end
      tick();
      rd_req = 1'b0;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    tick();
  endtask

  initial begin : stimulus
    rst       = 1'b1;
    start     = 1'b0;
    bank_sel  = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    rd_addr   = '0;
    rd_req    = 1'b0;
    model_bv  = '0;
    model_err = 1'b0;
    @(negedge clk);
    repeat (3) tick();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_bank_valid", 32'(bank_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);

    // Bank 1 with i mod 54, then read back entry 10.
    do_load(1, 95, 0, -1, '0, 1'b0, -1, '0, -1);
    check("bank_valid_b1", 32'(bank_valid), 32'b010);
    do_read(9'd106);

    // Random full loads with stream gaps, then random reads including out-of-range.
    do_load(0, 95, 1, -1, '0, 1'b1, -1, '0, -1);
    do_load(2, 95, 1, -1, '0, 1'b1, -1, '0, -1);
    check("bank_valid_all", 32'(bank_valid), 32'b111);
    repeat (12) do_read(ADDRW'($urandom_range(0, 319)));

    // Early in_last -> error; restart clears it.
    do_load(0, 50, 0, -1, '0, 1'b0, -1, '0, -1);
    check("early_last_err", 32'(err), 32'd1);
    check("early_last_bank_valid", 32'(bank_valid), 32'(model_bv));
    check("early_last_in_ready", 32'(in_ready), 32'd0);
    do_load(0, 95, 1, -1, '0, 1'b1, -1, '0, -1);
    // Missing in_last on the final beat -> error.
    do_load(1, -1, 1, -1, '0, 1'b0, -1, '0, -1);
    check("missing_last_err", 32'(err), 32'd1);

    // Illegal bank index.
    pulse_start(3);
    for (int k = 0; k < 4; k++) begin
      check("bad_bank_busy", 32'(busy), 32'd0);
      tick();
    end
    check("bad_bank_err", 32'(err), 32'd1);

    // Out-of-Z value at beat 5, then the skip marker at beat 5.
    do_load(0, 95, 0, 5, 7'd27, 1'b0, -1, '0, -1);
    check("range_err", 32'(err), 32'(model_err));
    do_load(0, 95, 0, 5, 7'h7F, 1'b0, -1, '0, -1);
    check("skip_accepted", 32'(bank_valid), 32'(model_bv));
    do_load(1, 95, 1, -1, '0, 1'b1, -1, '0, -1);

    // Read-first collision at address 200 (beat 8 of bank 2), then an out-of-range read.
    do_load(2, 95, 1, -1, '0, 1'b0, 8, 9'd200, -1);
    do_read(9'd300);

    // Reset in the middle of a bank-2 load, then recover with a gapped load.
    do_load(2, 95, 1, -1, '0, 1'b1, -1, '0, 40);
    do_load(2, 95, 1, -1, '0, 1'b1, -1, '0, -1);
    repeat (10) do_read(ADDRW'($urandom_range(0, 319)));

    repeat (3) tick();
    check("events_drained", 32'(ev_q.size()), 32'd0);
    check("reads_drained", 32'(rd_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
